// File: rtl/exec_arith_unit_if.sv
// exec_arith_unit_if: operand/result bundle between the decode/execute and execute/memory pipe registers
interface exec_arith_unit_if #(parameter int WIDTH = 32);
    logic             valid_in;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] offset;
    logic             branch;
    logic             not_equal;
    logic             valid_out;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_branch;
    logic             pc_src;
    modport master (
        output valid_in, src_a, src_b, alu_control, pc_in, offset, branch, not_equal,
        input  valid_out, alu_out, zero, pc_plus4, pc_branch, pc_src
    );
    modport slave (
        input  valid_in, src_a, src_b, alu_control, pc_in, offset, branch, not_equal,
        output valid_out, alu_out, zero, pc_plus4, pc_branch, pc_src
    );
endinterface

// File: rtl/exec_arith_unit.sv
// exec_arith_unit: registered ALU, PC+4, branch-target adder and branch decision with 1-cycle latency
module exec_arith_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    exec_arith_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] pc4;
    logic             eq;
    assign sh  = bus.src_b[SHW-1:0];
    assign pc4 = bus.pc_in + WIDTH'(4);
    assign eq  = bus.src_a == bus.src_b;
    always_comb begin
        res = '0;
        case (bus.alu_control)
            4'd0:  res = bus.src_a + bus.src_b;
            4'd1:  res = bus.src_a - bus.src_b;
            4'd2:  res = bus.src_a & bus.src_b;
            4'd3:  res = bus.src_a | bus.src_b;
            4'd4:  res = bus.src_a ^ bus.src_b;
            4'd5:  res = ~(bus.src_a | bus.src_b);
            4'd6:  res = bus.src_a << sh;
            4'd7:  res = bus.src_a >> sh;
            4'd8:  res = $signed(bus.src_a) >>> sh;
            4'd9:  res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
            4'd10: res = {{(WIDTH-1){1'b0}}, bus.src_a < bus.src_b};
            4'd11: res = bus.src_a * bus.src_b;
            4'd12: res = bus.src_b;
            default: res = '0;
        endcase
    end
    // pc_src is a one-shot decision, so it drops on bubbles while data registers hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.valid_out <= 1'b0;
            bus.alu_out   <= '0;
            bus.zero      <= 1'b0;
            bus.pc_plus4  <= '0;
            bus.pc_branch <= '0;
            bus.pc_src    <= 1'b0;
        end else begin
            bus.valid_out <= bus.valid_in;
            bus.pc_src    <= bus.valid_in & bus.branch & (bus.not_equal ^ eq);
            if (bus.valid_in) begin
                bus.alu_out   <= res;
                bus.zero      <= res == '0;
                bus.pc_plus4  <= pc4;
                bus.pc_branch <= pc4 + bus.offset;
            end
        end
    end
endmodule

// File: tb/tb_exec_arith_unit.sv
// tb_exec_arith_unit: directed and randomized checks of exec_arith_unit against a behavioural model
module tb_exec_arith_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic        m_vout, m_zero, m_psrc;
    logic [31:0] m_alu, m_p4, m_pb;
    exec_arith_unit_if #(.WIDTH(32)) bus ();
    exec_arith_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        int s;
        logic [63:0] p;
        s = int'(b[4:0]);
        p = {32'd0, a} * {32'd0, b};
        case (op)
            0: return a + b;
            1: return a + ~b + 32'd1;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return a << s;
            7: return a >> s;
            8: return (a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'h0);
            9: return ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
            10: return (a < b) ? 32'd1 : 32'd0;
            11: return p[31:0];
            12: return b;
            default: return 32'd0;
        endcase
    endfunction
    task automatic clear_model();
        m_vout = 0; m_zero = 0; m_psrc = 0; m_alu = 0; m_p4 = 0; m_pb = 0;
    endtask
    task automatic check_all(string tag);
        chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(m_vout));
        chk({tag, ".alu_out"}, bus.alu_out, m_alu);
        chk({tag, ".zero"}, 32'(bus.zero), 32'(m_zero));
        chk({tag, ".pc_plus4"}, bus.pc_plus4, m_p4);
        chk({tag, ".pc_branch"}, bus.pc_branch, m_pb);
        chk({tag, ".pc_src"}, 32'(bus.pc_src), 32'(m_psrc));
    endtask
    task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                         logic [31:0] pc, logic [31:0] off, logic br, logic ne);
        bus.valid_in = v; bus.src_a = a; bus.src_b = b; bus.alu_control = op;
        bus.pc_in = pc; bus.offset = off; bus.branch = br; bus.not_equal = ne;
    endtask
    task automatic apply(string tag, logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                         logic [31:0] pc, logic [31:0] off, logic br, logic ne);
        drive(v, a, b, op, pc, off, br, ne);
        m_vout = v;
        m_psrc = v && br && (ne ? (a != b) : (a == b));
        if (v) begin
            m_alu  = ref_alu(int'(op), a, b);
            m_zero = (m_alu == 0);
            m_p4   = pc + 32'd4;
            m_pb   = pc + 32'd4 + off;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask
    task automatic apply_rand(string tag);
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
        apply(tag, $urandom_range(0, 3) != 0, a, b, 4'($urandom_range(0, 15)),
              $urandom, $urandom, 1'($urandom), 1'($urandom));
    endtask
    initial begin
        clear_model();
        drive(1'b1, $urandom, $urandom, 4'd0, $urandom, $urandom, 1'b1, 1'b0);
        #2;
        check_all("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset_hold");
        reset = 1'b0;
        apply("first_capture", 1, 32'd3, 32'd4, 4'd0, 32'h200, 32'h10, 1'b0, 1'b0);
        chk("first_capture.alu_lit", bus.alu_out, 32'd7);
        apply("add_wrap", 1, 32'hFFFFFFFF, 32'd1, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("add_wrap.lit", bus.alu_out, 32'h0);
        chk("add_wrap.zero_lit", 32'(bus.zero), 32'd1);
        apply("sub", 1, 32'd5, 32'd7, 4'd1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sub.lit", bus.alu_out, 32'hFFFFFFFE);
        apply("sra", 1, 32'h80000000, 32'd4, 4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sra.lit", bus.alu_out, 32'hF8000000);
        apply("slt", 1, 32'hFFFFFFFF, 32'd1, 4'd9, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("slt.lit", bus.alu_out, 32'd1);
        apply("sltu", 1, 32'hFFFFFFFF, 32'd1, 4'd10, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sltu.lit", bus.alu_out, 32'd0);
        apply("op14", 1, 32'h1234, 32'h5678, 4'd14, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("op14.lit", bus.alu_out, 32'd0);
        apply("sll_mask", 1, 32'd1, 32'd33, 4'd6, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sll_mask.lit", bus.alu_out, 32'd2);
        apply("pc_add", 1, 32'd1, 32'd2, 4'd11, 32'h100, 32'hFFFFFFF0, 1'b0, 1'b0);
        chk("pc_add.p4_lit", bus.pc_plus4, 32'h104);
        chk("pc_add.pb_lit", bus.pc_branch, 32'hF4);
        apply("beq_taken", 1, 32'd9, 32'd9, 4'd1, 32'h40, 32'h8, 1'b1, 1'b0);
        chk("beq_taken.lit", 32'(bus.pc_src), 32'd1);
        apply("bne_eq", 1, 32'd9, 32'd9, 4'd1, 32'h40, 32'h8, 1'b1, 1'b1);
        chk("bne_eq.lit", 32'(bus.pc_src), 32'd0);
        apply("bne_taken", 1, 32'd9, 32'd8, 4'd1, 32'h40, 32'h8, 1'b1, 1'b1);
        chk("bne_taken.lit", 32'(bus.pc_src), 32'd1);
        apply("nobranch", 1, 32'd9, 32'd9, 4'd1, 32'h40, 32'h8, 1'b0, 1'b0);
        chk("nobranch.lit", 32'(bus.pc_src), 32'd0);
        apply("vg_load", 1, 32'd10, 32'd10, 4'd0, 32'h300, 32'h20, 1'b1, 1'b0);
        apply("vg_hold", 0, 32'd1, 32'd1, 4'd1, 32'h900, 32'h80, 1'b1, 1'b0);
        chk("vg_hold.alu_lit", bus.alu_out, 32'd20);
        chk("vg_hold.p4_lit", bus.pc_plus4, 32'h304);
        chk("vg_hold.pb_lit", bus.pc_branch, 32'h324);
        chk("vg_hold.psrc_lit", 32'(bus.pc_src), 32'd0);
        chk("vg_hold.vout_lit", 32'(bus.valid_out), 32'd0);
        for (int i = 0; i < 300; i++) apply_rand("rand");
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(1'b1, $urandom, $urandom, 4'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        clear_model();
        #1;
        check_all("midreset_async");
        @(posedge clk);
        #1;
        check_all("midreset_hold");
        reset = 1'b0;
        apply("after_reset", 1, 32'h0F0F0F0F, 32'hFF00FF00, 4'd4, 32'h1000, 32'h4, 1'b1, 1'b1);
        for (int i = 0; i < 200; i++) apply_rand("rand2");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_arith_unit.md
Name: exec_arith_unit

Overview:
- Registered arithmetic slice of the 5-stage pipeline.
- Combines four functions:
  - the ALU,
  - the PC+4 incrementer,
  - the branch-target adder,
  - the branch-decision AND gate.
- Sits between the decode/execute pipe register and the execute/memory pipe register.
- All results are captured in one output register stage, so downstream logic sees a clean 1-cycle-latency interface.

Parameters:
- WIDTH, 32, datapath width. Must be a power of 2 and at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridable).

Ports:
- CLK  in  1  clock; rising edge active.
- RESET  in  1  asynchronous, active-high reset.
- VALID_IN  in  1  input operands valid this cycle.
- SRC_A  in  WIDTH  ALU operand A.
- SRC_B  in  WIDTH  ALU operand B; low SHW bits are the shift amount.
- ALU_CONTROL  in  4  operation select.
- PC_IN  in  WIDTH  current PC.
- OFFSET  in  WIDTH  sign-extended immediate, already word-shifted.
- BRANCH  in  1  instruction is a conditional branch.
- NOT_EQUAL  in  1  selects the branch condition: 0 = taken when SRC_A==SRC_B; 1 = taken when SRC_A!=SRC_B.
- VALID_OUT  out  1  registered VALID_IN.
- ALU_OUT  out  WIDTH  registered ALU result.
- ZERO  out  1  registered (ALU result == 0).
- PC_PLUS4  out  WIDTH  registered PC_IN + 4.
- PC_BRANCH  out  WIDTH  registered (PC_IN + 4) + OFFSET.
- PC_SRC  out  1  registered BRANCH AND condition.

Behaviour:
- Reset:
  - RESET high clears every output register to 0 immediately, without waiting for a CLK edge.
  - Outputs hold 0 while RESET is high.
  - The first capture happens on the first rising CLK edge after RESET falls.
- Latency: exactly 1 cycle. Outputs update on every rising edge.
- Register enable:
  - When VALID_IN = 1, data registers load new values.
  - When VALID_IN = 0, data registers hold their previous values, except PC_SRC, which is forced to 0.
  - VALID_OUT always follows VALID_IN with 1 cycle delay.
- Arithmetic rules (all modulo 2^WIDTH, overflow silently wraps, no flags besides ZERO):
  - PC_PLUS4 = PC_IN + 4.
  - PC_BRANCH = PC_PLUS4 + OFFSET. OFFSET is treated as two's complement, so negative offsets branch backwards.
- ALU_CONTROL encoding (combinational result, then registered):
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOR.
  - 6 SLL: A << B[SHW-1:0].
  - 7 SRL: logical A >> B[SHW-1:0].
  - 8 SRA: arithmetic, sign-filled.
  - 9 SLT: signed A<B gives 1, else 0; zero-extended to WIDTH.
  - 10 SLTU: unsigned compare.
  - 11 MUL: low WIDTH bits of A*B.
  - 12 PASSB: B.
  - 13-15: result 0.
- Shift amounts: only B[SHW-1:0] are used; upper bits of B are ignored (shift by 32 = shift by 0 for WIDTH=32).
- Branch decision:
  - EQ = (SRC_A == SRC_B), full-width compare.
  - PC_SRC = BRANCH & (NOT_EQUAL ? ~EQ : EQ) & VALID_IN.
  - When BRANCH = 0, PC_SRC = 0 regardless of operands.
- ZERO is computed from the same-cycle ALU result and registered alongside ALU_OUT.
- Combinational paths: none from inputs to outputs; all outputs come from flops.

Test Plan:
- Reset: drive random inputs with RESET asserted mid-cycle -> all outputs 0 immediately; after release, the first edge with VALID_IN=1 captures the inputs.
- ALU sweep, one op per cycle each checked one cycle later:
  - A=0xFFFFFFFF, B=1, ADD -> 0x00000000, ZERO=1.
  - SUB with A=5, B=7 -> 0xFFFFFFFE.
  - SRA with A=0x80000000, B=4 -> 0xF8000000.
  - SLT with A=-1, B=1 -> 1.
  - SLTU with A=-1, B=1 -> 0.
  - ALU_CONTROL=14 -> 0.
- Shift masking: A=1, B=33, SLL -> 0x00000002.
- PC adders: PC_IN=0x100, OFFSET=0xFFFFFFF0 -> PC_PLUS4=0x104, PC_BRANCH=0xF4.
- Branch gate:
  - BRANCH=1, NOT_EQUAL=0, A=B=9 -> PC_SRC=1.
  - Same operands with NOT_EQUAL=1 -> PC_SRC=0.
  - A=9, B=8, NOT_EQUAL=1 -> PC_SRC=1.
  - BRANCH=0 with any operands -> PC_SRC=0.
- Valid gating: a VALID_IN=1 cycle followed by a VALID_IN=0 cycle with new operands -> ALU_OUT, PC_PLUS4 and PC_BRANCH hold the earlier values, PC_SRC=0, VALID_OUT=0.
